// File: rtl/conv_pkg.sv
// Shared types and constants for the conv accelerator memory arbiter.
package conv_pkg;

    localparam int N_REQ       = 3;
    localparam int BUS_BW      = 16;
    localparam int ADDR_BW     = 16;
    localparam int LEN_BW      = 14;
    localparam int INPUT_DEPTH = 15488;
    localparam int IDX_W       = $clog2(N_REQ);

    localparam int REQ_INPUT  = 0;
    localparam int REQ_WEIGHT = 1;
    localparam int REQ_OUTPUT = 2;

    typedef enum logic [1:0] {IDLE, ARB, BURST, DONE} arb_state_t;

    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t next_idx(input idx_t i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter
    import conv_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  idx_t             rr_ptr,
    output logic [N_REQ-1:0] pick,
    output idx_t             pick_idx
);

    int j;

    // Scan farthest-first so the candidate nearest rr_ptr overwrites the rest.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        j        = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[idx_t'(j)]) begin
                pick              = '0;
                pick[idx_t'(j)]   = 1'b1;
                pick_idx          = idx_t'(j);
            end
        end
    end

endmodule

// File: rtl/conv_mem_arbiter.sv
// Burst arbiter sharing the external memory port among the conv requesters.
module conv_mem_arbiter
    import conv_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ-1:0][ADDR_BW-1:0]  req_addr,
    input  logic [N_REQ-1:0][LEN_BW-1:0]   req_len,
    input  logic [N_REQ-1:0]               req_we,
    input  logic [N_REQ-1:0][BUS_BW-1:0]   wr_data,
    output logic [N_REQ-1:0]               gnt,
    output logic                           beat,
    output logic                           rd_valid,
    output logic [BUS_BW-1:0]              rd_data,
    output logic [N_REQ-1:0]               done,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_BW-1:0]             mem_addr,
    output logic [BUS_BW-1:0]              mem_wdata,
    input  logic                           mem_ready,
    input  logic [BUS_BW-1:0]              mem_rdata
);

    arb_state_t         state;
    idx_t               rr_ptr;
    idx_t               idx_q;
    logic [ADDR_BW-1:0] base_q;
    logic [LEN_BW-1:0]  len_q;
    logic               we_q;
    logic [LEN_BW-1:0]  cnt;
    logic [N_REQ-1:0]   pick;
    idx_t               pick_idx;
    logic               last;

    rr_arbiter u_rr (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign mem_en    = (state == BURST);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = base_q + ADDR_BW'(cnt);
    assign mem_wdata = mem_en ? wr_data[idx_q] : '0;
    assign beat      = mem_en & mem_ready;
    assign last      = (cnt == len_q - LEN_BW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            idx_q    <= '0;
            base_q   <= '0;
            len_q    <= '0;
            we_q     <= 1'b0;
            cnt      <= '0;
            gnt      <= '0;
            done     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            done     <= '0;
            rd_valid <= beat & ~we_q;
            if (beat && !we_q) rd_data <= mem_rdata;
            unique case (state)
                IDLE: begin
                    if (|req) state <= ARB;
                end
                ARB: begin
                    if (!(|req)) begin
                        state <= IDLE;
                    end else begin
                        idx_q  <= pick_idx;
                        base_q <= req_addr[pick_idx];
                        len_q  <= req_len[pick_idx];
                        we_q   <= req_we[pick_idx];
                        cnt    <= '0;
                        // Zero-length bursts complete without touching memory.
                        if (req_len[pick_idx] == '0) begin
                            state <= DONE;
                            done  <= pick;
                        end else begin
                            state <= BURST;
                            gnt   <= pick;
                        end
                    end
                end
                BURST: begin
                    if (mem_ready) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state <= DONE;
                            gnt   <= '0;
                            done  <= gnt;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    rr_ptr <= next_idx(idx_q);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed scoreboard bench for conv_mem_arbiter.
module tb_conv_mem_arbiter;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        req;
    logic [2:0][15:0]  req_addr;
    logic [2:0][13:0]  req_len;
    logic [2:0]        req_we;
    logic [2:0][15:0]  wr_data;
    logic [2:0]        gnt;
    logic              beat;
    logic              rd_valid;
    logic [15:0]       rd_data;
    logic [2:0]        done;
    logic              mem_en;
    logic              mem_we;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ready;
    logic [15:0]       mem_rdata;

    conv_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_we    (req_we),
        .wr_data   (wr_data),
        .gnt       (gnt),
        .beat      (beat),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_model(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    assign mem_rdata = rd_model(mem_addr);

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [2:0]  gnt;
        logic [15:0] wd;
    } beat_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } rd_t;

    beat_t       exp_beats[$];
    rd_t         exp_rd[$];
    logic [2:0]  exp_done[$];
    logic        rdy_pat[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nbeats = 0;
    bit track = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset && beat) nbeats++;
        if (reset && track) begin
            if (rd_valid) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_rd_valid", 1, 0);
                end else begin
                    rd_t r;
                    r = exp_rd.pop_front();
                    chk("rd_data", rd_data, r.data);
                    chk("rd_lag", cyc, r.cyc);
                end
            end
            if (mem_en) begin
                if (exp_beats.size() == 0) begin
                    chk("unexpected_mem_en", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_beats[0];
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", mem_we, e.we);
                    chk("gnt", gnt, e.gnt);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wd);
                    if (mem_ready) begin
                        void'(exp_beats.pop_front());
                        if (!e.we) exp_rd.push_back('{rd_model(e.addr), cyc + 1});
                    end
                end
            end
            if (done != 3'b000) begin
                if (exp_done.size() == 0) chk("unexpected_done", done, 0);
                else chk("done", done, exp_done.pop_front());
            end
        end
    end

    task automatic push_burst(input int r, input logic [15:0] a,
                              input int len, input logic we,
                              input logic [15:0] wd);
        logic [15:0] ad;
        logic [2:0]  g;
        g = 3'b001 << r;
        for (int i = 0; i < len; i++) begin
            ad = a + 16'(i);
            exp_beats.push_back('{ad, we, g, wd});
        end
        exp_done.push_back(g);
    endtask

    task automatic set_req(input int r, input logic [15:0] a,
                           input logic [13:0] len, input logic we);
        req_addr[r] = a;
        req_len[r]  = len;
        req_we[r]   = we;
        req[r]      = 1'b1;
    endtask

    task automatic run(input string tag, input int budget);
        int n = 0;
        while ((exp_beats.size() != 0 || exp_done.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            req = req & ~done;
            if (mem_en && rdy_pat.size() != 0) mem_ready = rdy_pat.pop_front();
            else mem_ready = 1'b1;
            n++;
        end
        chk({tag, "_timeout"}, n < budget, 1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_rd_drained"}, exp_rd.size(), 0);
    endtask

    initial begin
        int nb0;
        int n;
        reset     = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_len   = '0;
        req_we    = '0;
        wr_data   = '0;
        mem_ready = 1'b1;
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // 1: single read burst
        set_req(0, 16'h0100, 14'd4, 1'b0);
        push_burst(0, 16'h0100, 4, 1'b0, 16'h0);
        run("t1", 40);

        // 2: write burst with backpressure
        wr_data[2] = 16'hBEEF;
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        nb0 = nbeats;
        set_req(2, 16'h0200, 14'd3, 1'b1);
        push_burst(2, 16'h0200, 3, 1'b1, 16'hBEEF);
        run("t2", 40);
        chk("t2_beats", nbeats - nb0, 3);

        // 3: round robin
        set_req(0, 16'h1000, 14'd2, 1'b0);
        set_req(1, 16'h2000, 14'd2, 1'b0);
        set_req(2, 16'h3000, 14'd2, 1'b0);
        push_burst(0, 16'h1000, 2, 1'b0, 16'h0);
        push_burst(1, 16'h2000, 2, 1'b0, 16'h0);
        push_burst(2, 16'h3000, 2, 1'b0, 16'h0);
        run("t3a", 80);
        set_req(0, 16'h1100, 14'd2, 1'b0);
        set_req(2, 16'h3100, 14'd2, 1'b0);
        push_burst(0, 16'h1100, 2, 1'b0, 16'h0);
        push_burst(2, 16'h3100, 2, 1'b0, 16'h0);
        run("t3b", 60);

        // 4: address wrap, then zero length
        set_req(1, 16'hFFFE, 14'd4, 1'b0);
        push_burst(1, 16'hFFFE, 4, 1'b0, 16'h0);
        run("t4a", 40);
        set_req(0, 16'h0400, 14'd0, 1'b0);
        exp_done.push_back(3'b001);
        @(posedge clk); #1;
        chk("t4_done_early", done, 0);
        @(posedge clk); #1;
        chk("t4_done_2cyc", done, 3'b001);
        chk("t4_gnt_zero", gnt, 0);
        chk("t4_no_mem_en", mem_en, 0);
        req = '0;
        run("t4b", 10);

        // 5: reset in the middle of a full input-map burst
        track = 1'b0;
        nb0 = nbeats;
        set_req(0, 16'h0000, 14'(conv_pkg::INPUT_DEPTH), 1'b0);
        n = 0;
        while (nbeats - nb0 < 5 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_reach_beat5", nbeats - nb0, 5);
        reset = 1'b0;
        #1;
        chk("t5_gnt", gnt, 0);
        chk("t5_mem_en", mem_en, 0);
        chk("t5_mem_we", mem_we, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_wdata", mem_wdata, 0);
        chk("t5_beat", beat, 0);
        chk("t5_rd_valid", rd_valid, 0);
        chk("t5_rd_data", rd_data, 0);
        chk("t5_done", done, 0);
        req = '0;
        exp_beats.delete();
        exp_rd.delete();
        exp_done.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        track = 1'b1;
        set_req(1, 16'h4000, 14'd2, 1'b0);
        push_burst(1, 16'h4000, 2, 1'b0, 16'h0);
        run("t5", 40);

        // 6: request dropped mid-burst
        nb0 = nbeats;
        set_req(0, 16'h0500, 14'd8, 1'b0);
        push_burst(0, 16'h0500, 8, 1'b0, 16'h0);
        n = 0;
        while (nbeats - nb0 < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        req[0] = 1'b0;
        run("t6", 40);
        chk("t6_beats", nbeats - nb0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
